// File: rtl/stream_mux_pkg.sv
// Shared parameters, helper function and channel-id type for stream_mux_n.
// STREAM_MUX_RR_ARB_EN selects round-robin arbitration instead of manual select.
package stream_mux_pkg;

    localparam int W_DEF = 8;
    localparam int N_DEF = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int SW_DEF = clog2(N_DEF);

    typedef logic [SW_DEF-1:0] ch_id_t;

endpackage

// File: rtl/stream_mux_n_if.sv
// Input channels, select and output stream of the N:1 stream mux.
// STREAM_MUX_RR_ARB_EN: sel is ignored by the mux when defined.
interface stream_mux_n_if
    import stream_mux_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
);

    localparam int SW = clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin grant: lowest requester at or after ptr, else lowest overall.
// Used by stream_mux_n only when STREAM_MUX_RR_ARB_EN is defined.
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_ok
);

    logic [SW-1:0] w_hi_idx;
    logic [SW-1:0] w_lo_idx;
    logic          w_hi_ok;
    logic          w_lo_ok;

    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_hi_ok  = 1'b0;
        w_lo_ok  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_ok  = 1'b1;
                w_lo_idx = SW'(i);
                if (SW'(i) >= ptr) begin
                    w_hi_ok  = 1'b1;
                    w_hi_idx = SW'(i);
                end
            end
        end
    end

    assign gnt_idx = w_hi_ok ? w_hi_idx : w_lo_idx;
    assign gnt_ok  = w_lo_ok;

endmodule

// File: rtl/stream_mux_n.sv
// N:1 stream mux with one registered output stage and valid/ready handshake.
// STREAM_MUX_RR_ARB_EN: round-robin over in_valid instead of manual sel.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input logic           clk,
    input logic           rst_n,
    stream_mux_n_if.slave bus
);

    localparam int SW = clog2(N);
    localparam int NP = 1 << SW;

    logic [W-1:0]  w_ch_data [NP];
    logic [SW-1:0] w_g;
    logic          w_grant_ok;
    logic          w_can_load;
    logic          w_xfer;
    logic [N-1:0]  w_rdy;

    logic [W-1:0]  r_data;
    logic [SW-1:0] r_ch;
    logic          r_valid;

    // Pad to a power of two so any grant index selects a defined value.
    for (genvar i = 0; i < NP; i++) begin : g_pad
        if (i < N) begin : g_ch
            assign w_ch_data[i] = bus.in_data[i*W +: W];
        end else begin : g_zero
            assign w_ch_data[i] = '0;
        end
    end

`ifdef STREAM_MUX_RR_ARB_EN
    logic [SW-1:0] r_rr_ptr;
    logic          w_unused_sel;

    assign w_unused_sel = ^bus.sel;

    rr_arbiter_n #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_g),
        .gnt_ok  (w_grant_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_g == SW'(N - 1)) ? '0 : w_g + 1'b1;
        end
    end
`else
    logic [NP-1:0] w_sel_ok;

    for (genvar i = 0; i < NP; i++) begin : g_ok
        assign w_sel_ok[i] = (i < N);
    end

    assign w_g        = bus.sel;
    assign w_grant_ok = w_sel_ok[bus.sel];
`endif

    assign w_can_load = !r_valid || bus.out_ready;

    always_comb begin
        w_rdy = '0;
        for (int i = 0; i < N; i++) begin
            w_rdy[i] = rst_n && w_can_load && w_grant_ok
                       && (w_g == SW'(i));
        end
    end

    assign w_xfer = |(bus.in_valid & w_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (w_can_load) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_ch_data[w_g];
                r_ch   <= w_g;
            end
        end
    end

    assign bus.in_ready  = w_rdy;
    assign bus.out_data  = r_data;
    assign bus.out_ch    = r_ch;
    assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_n.sv
// Randomized + directed bench for stream_mux_n (N=4 and N=5 instances).
// Honours STREAM_MUX_RR_ARB_EN for the reference model and RR checks.
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_n_if #(.W(8), .N(4)) b4 ();
    stream_mux_n_if #(.W(8), .N(5)) b5 ();

    stream_mux_n #(.W(8), .N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    stream_mux_n #(.W(8), .N(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
    );

    int checks = 0;
    int failures = 0;
    int nch [2] = '{4, 5};

    logic [39:0] d [2];
    logic [4:0]  v [2];
    logic [2:0]  s [2];
    logic        ordy [2];

    bit          ev [2];
    logic [7:0]  ed [2];
    int          ec [2];
    int          ptr [2];

    assign b4.in_data   = d[0][31:0];
    assign b4.in_valid  = v[0][3:0];
    assign b4.sel       = s[0][1:0];
    assign b4.out_ready = ordy[0];
    assign b5.in_data   = d[1];
    assign b5.in_valid  = v[1];
    assign b5.sel       = s[1];
    assign b5.out_ready = ordy[1];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void grant(input int m, output int g, output bit ok);
`ifdef STREAM_MUX_RR_ARB_EN
        ok = 1'b0;
        g = 0;
        for (int k = 0; k < nch[m]; k++) begin
            int c;
            c = (ptr[m] + k) % nch[m];
            if (!ok && v[m][c]) begin
                ok = 1'b1;
                g = c;
            end
        end
`else
        g = (m == 0) ? int'(s[0][1:0]) : int'(s[1]);
        ok = (g < nch[m]);
`endif
    endfunction

    function automatic int exp_rdy(input int m);
        int g;
        bit ok;
        bit can;
        grant(m, g, ok);
        can = !ev[m] || ordy[m];
        return (rst_n && can && ok) ? (1 << g) : 0;
    endfunction

    function automatic logic [4:0] rdy_obs(input int m);
        return (m == 0) ? {1'b0, b4.in_ready} : b5.in_ready;
    endfunction

    function automatic logic [11:0] out_obs(input int m);
        if (m == 0)
            return {b4.out_valid, 1'b0, b4.out_ch, b4.out_data};
        return {b5.out_valid, b5.out_ch, b5.out_data};
    endfunction

    task automatic chk_out(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_out"}, 64'(out_obs(m)),
                64'({ev[m], 3'(ec[m]), ed[m]}));
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ev[m] = 1'b0;
            ed[m] = '0;
            ec[m] = 0;
            ptr[m] = 0;
        end
    endtask

    // One clock: called just after a falling edge with inputs applied.
    task automatic cyc();
        #1;
        for (int m = 0; m < 2; m++) begin
            int r;
            int g;
            bit ok;
            r = exp_rdy(m);
            chk("in_ready", 64'(rdy_obs(m)), 64'(r));
            grant(m, g, ok);
            if (!ev[m] || ordy[m]) begin
                if ((r & int'(v[m])) != 0) begin
                    ev[m] = 1'b1;
                    ed[m] = d[m][g*8 +: 8];
                    ec[m] = g;
                    ptr[m] = (g + 1) % nch[m];
                end else begin
                    ev[m] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk_out("cyc");
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rdy4", 64'(b4.in_ready), 64'(0));
        chk("rst_rdy5", 64'(b5.in_ready), 64'(0));
        chk_out("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_all(input logic [4:0] vv, input logic [2:0] ss,
                           input logic rr);
        for (int m = 0; m < 2; m++) begin
            v[m] = vv;
            s[m] = ss;
            ordy[m] = rr;
        end
    endtask

    initial begin
        model_reset();
        d[0] = '0;
        d[1] = '0;
        set_all(5'h1f, 3'd0, 1'b1);
        #3;
        chk("init_rdy4", 64'(b4.in_ready), 64'(0));
        chk("init_rdy5", 64'(b5.in_ready), 64'(0));
        chk_out("init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat from channel 2.
        d[0] = 40'h00_00A5_0000;
        d[1] = 40'h00_00A5_0000;
        set_all(5'b00100, 3'd2, 1'b1);
        #1;
        chk("a5_rdy", 64'(b4.in_ready), 64'(4'b0100));
        cyc();
        chk("a5_data", 64'(b4.out_data), 64'(8'hA5));
        chk("a5_ch", 64'(b4.out_ch), 64'(2));
        chk("a5_vld", 64'(b4.out_valid), 64'(1));

        // Backpressure holds the beat and blocks all inputs.
        d[0] = 40'h00_1122_3344;
        d[1] = 40'h55_1122_3344;
        set_all(5'h1f, 3'd1, 1'b0);
        repeat (3) begin
            cyc();
            chk("bp_data", 64'(b4.out_data), 64'(8'hA5));
            chk("bp_rdy", 64'(b4.in_ready), 64'(0));
        end
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        cyc();
`ifdef STREAM_MUX_RR_ARB_EN
        chk("bp_next_ch", 64'(b4.out_ch), 64'(3));
`else
        chk("bp_next_ch", 64'(b4.out_ch), 64'(1));
        chk("bp_next_d", 64'(b4.out_data), 64'(8'h33));
`endif

        // Out-of-range select on the N=5 instance.
        set_all(5'h1f, 3'd5, 1'b1);
        cyc();
        cyc();
`ifndef STREAM_MUX_RR_ARB_EN
        chk("oor_rdy", 64'(b5.in_ready), 64'(0));
        chk("oor_vld", 64'(b5.out_valid), 64'(0));
`endif

        // Reset in the middle of a full-rate stream.
        set_all(5'h1f, 3'd3, 1'b1);
        cyc();
        cyc();
        do_reset();
        chk("post_rst_vld", 64'(b4.out_valid), 64'(0));
        cyc();
        chk("post_rst_hs", 64'(b4.out_valid), 64'(1));

        // Random traffic with one embedded reset.
        for (int it = 0; it < 400; it++) begin
            for (int m = 0; m < 2; m++) begin
                d[m] = 40'({$urandom(), $urandom()});
                v[m] = 5'($urandom());
                s[m] = 3'($urandom_range(0, 7));
                ordy[m] = ($urandom_range(0, 3) != 0);
            end
            if (it == 200) do_reset();
            cyc();
        end

`ifdef STREAM_MUX_RR_ARB_EN
        do_reset();
        set_all(5'h1f, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_seq", 64'(b4.out_ch), 64'(i % 4));
        end
        set_all(5'b00010, 3'd0, 1'b1);
        cyc();
        set_all(5'b01010, 3'd0, 1'b1);
        cyc();
        chk("rr_wrap0", 64'(b4.out_ch), 64'(3));
        cyc();
        chk("rr_wrap1", 64'(b4.out_ch), 64'(1));
        cyc();
        chk("rr_wrap2", 64'(b4.out_ch), 64'(3));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
